regfile_param: RTL
==================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning register address width; NUM_REGS = 2**ADDR_W.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have ports rd_addr1, rd_addr2  input  ADDR_W  read port addresses.
REQ-006 The block SHALL have ports rd_data1, rd_data2  output  DATA_W  read port data.
REQ-007 The block SHALL have ports rd_busy1, rd_busy2  output  1  scoreboard busy bit of the addressed register.
REQ-008 The block SHALL have ports wr_en  input  1, wr_addr  input  ADDR_W, wr_data  input  DATA_W, forming the main write port.
REQ-009 The block SHALL have ports r0_wr_en  input  1, r0_wr_data  input  DATA_W, forming the dedicated R0 write port for multiply/divide secondary results.
REQ-010 The block SHALL have ports lock_en  input  1, lock_addr  input  ADDR_W, used to mark the destination register busy at issue.
REQ-011 The block SHALL have port busy_vec  output  NUM_REGS  all scoreboard bits; bit i corresponds to register i.

Function
REQ-012 Register array and busy bits SHALL update only on the rising edge of clk.
REQ-013 Reads SHALL be combinational: rd_dataN = R[rd_addrN], and rd_busyN = busy[rd_addrN], with zero-cycle latency.
REQ-014 When wr_en=1, R[wr_addr] SHALL take wr_data at the next edge.
REQ-015 When r0_wr_en=1, R[0] SHALL take r0_wr_data at the next edge.
REQ-016 When wr_en=1, wr_addr=0 and r0_wr_en=1 occur together, the main port SHALL win and r0_wr_data SHALL be discarded.
REQ-017 When wr_en=1 with wr_addr!=0 and r0_wr_en=1 occur together, both writes SHALL complete in the same cycle.
REQ-018 When lock_en=1, busy[lock_addr] SHALL be set at the next edge.
REQ-019 A main write SHALL clear busy[wr_addr]; an R0 write SHALL clear busy[0].
REQ-020 When a lock and a clear target the same register in the same cycle, the set SHALL win, so busy=1.
REQ-021 Locking an already-busy register SHALL leave it busy with no error; clearing a non-busy register SHALL be a no-op.
REQ-022 Register 0 SHALL be a normal writable register, not hardwired to zero.

Reset
REQ-023 While reset=1 at an edge, all write and lock requests SHALL be ignored, including any request that arrives mid-operation.
REQ-024 Reset SHALL clear all busy bits, giving busy_vec=0.
REQ-025 Reset SHALL load R0..R15 with 0000, 7B18, 245B, FFFF, F0FF, 0051, 6666, 00FF, FF88, 0000, 0000, 3099, CCCC, 0002, 0011, 0000 (hex), in that order.
REQ-026 For DATA_W!=16, the preset values SHALL be zero-extended or truncated to DATA_W, and registers with index >=16 SHALL reset to 0.
REQ-027 Before the first reset, register contents SHALL be don't-care; the outputs SHALL be defined only after reset.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-029 With REGFILE_BYPASS_EN defined, a read whose address matches an active write in the same cycle SHALL return the incoming data and busy=0, using the priority in REQ-016.
REQ-030 Without REGFILE_BYPASS_EN, reads SHALL return the pre-edge array contents and busy bits, and the new value SHALL be visible one cycle later.
REQ-031 Bypass SHALL never apply while reset=1.

Verification
REQ-032 Assert reset for 1 cycle, then read all 16 addresses -> the data matches the REQ-025 table and busy_vec=0000.
REQ-033 Drive wr_en=1, wr_addr=5, wr_data=ABCD with rd_addr1=5 -> the same cycle returns ABCD with bypass and 0051 without it; the next cycle returns ABCD in both builds.
REQ-034 Drive wr_en=1, wr_addr=0, wr_data=1111 together with r0_wr_en=1, r0_wr_data=2222 -> R0=1111; then drive wr_addr=3 with 3333 together with r0 2222 -> R3=3333 and R0=2222.
REQ-035 Drive lock_en=1, lock_addr=7; next cycle drive wr_en=1, wr_addr=7 together with lock_en=1, lock_addr=7 -> busy[7] stays 1; next cycle drive a write to 7 alone -> busy[7]=0.
REQ-036 Hold reset=1 while wr_en=1, wr_addr=2, wr_data=0000 and lock_en=1, lock_addr=2 -> R2=245B and busy[2]=0 after the edge.
REQ-037 Build with DATA_W=32, ADDR_W=5 and apply reset -> R1=00007B18 and R20=00000000, and busy_vec is 32 bits of zero.

Source files
------------

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parameterised register file with busy scoreboard and dedicated R0 write port
// Optional same-cycle write-to-read forwarding under `REGFILE_BYPASS_EN.
module regfile_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        rd_addr1,
  input  logic [ADDR_W-1:0]        rd_addr2,
  output logic [DATA_W-1:0]        rd_data1,
  output logic [DATA_W-1:0]        rd_data2,
  output logic                     rd_busy1,
  output logic                     rd_busy2,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     r0_wr_en,
  input  logic [DATA_W-1:0]        r0_wr_data,
  input  logic                     lock_en,
  input  logic [ADDR_W-1:0]        lock_addr,
  output logic [(2**ADDR_W)-1:0]   busy_vec
);

  localparam int NUM_REGS = 2**ADDR_W;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  // Preset values are 16 bits wide; widen through a scratch vector so any DATA_W works.
  function automatic logic [DATA_W-1:0] preset(input int idx);
    logic [15:0]        v;
    logic [DATA_W+15:0] w;
    case (idx)
      0:       v = 16'h0000;
      1:       v = 16'h7B18;
      2:       v = 16'h245B;
      3:       v = 16'hFFFF;
      4:       v = 16'hF0FF;
      5:       v = 16'h0051;
      6:       v = 16'h6666;
      7:       v = 16'h00FF;
      8:       v = 16'hFF88;
      9:       v = 16'h0000;
      10:      v = 16'h0000;
      11:      v = 16'h3099;
      12:      v = 16'hCCCC;
      13:      v = 16'h0002;
      14:      v = 16'h0011;
      default: v = 16'h0000;
    endcase
    w = '0;
    w[15:0] = v;
    return w[DATA_W-1:0];
  endfunction

  // Clears first, then lock, so a same-cycle lock keeps the register busy.
  always_comb begin
    busy_next = busy;
    if (wr_en)    busy_next[wr_addr]   = 1'b0;
    if (r0_wr_en) busy_next[0]         = 1'b0;
    if (lock_en)  busy_next[lock_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i[ADDR_W-1:0]] <= preset(i);
      end
      busy <= '0;
    end else begin
      // Main port is assigned last so it overrides the R0 port on a collision.
      if (r0_wr_en) regs[0]       <= r0_wr_data;
      if (wr_en)    regs[wr_addr] <= wr_data;
      busy <= busy_next;
    end
  end

  assign busy_vec = busy;

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rd_data1 = regs[rd_addr1];
    rd_busy1 = busy[rd_addr1];
    rd_data2 = regs[rd_addr2];
    rd_busy2 = busy[rd_addr2];
    if (!reset) begin
      if (r0_wr_en && rd_addr1 == '0) begin
        rd_data1 = r0_wr_data;
        rd_busy1 = 1'b0;
      end
      if (wr_en && wr_addr == rd_addr1) begin
        rd_data1 = wr_data;
        rd_busy1 = 1'b0;
      end
      if (r0_wr_en && rd_addr2 == '0) begin
        rd_data2 = r0_wr_data;
        rd_busy2 = 1'b0;
      end
      if (wr_en && wr_addr == rd_addr2) begin
        rd_data2 = wr_data;
        rd_busy2 = 1'b0;
      end
    end
  end
`else
  assign rd_data1 = regs[rd_addr1];
  assign rd_busy1 = busy[rd_addr1];
  assign rd_data2 = regs[rd_addr2];
  assign rd_busy2 = busy[rd_addr2];
`endif

endmodule
